// File: rtl/effects_pkg.sv
// Shared types and defaults for the effects datapath blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package effects_pkg;

  // Default datapath widths for the effects chain.
  localparam int SAMPLE_W_DEF = 16;
  localparam int GAIN_W_DEF   = 11;

  // Largest shared-pipeline latency the scheduler supports. The capture
  // counter has to reach PIPE_LAT+1, so 4 bits covers the whole range.
  localparam int PIPE_LAT_MAX = 7;
  localparam int DLY_CNT_W    = 4;

  // Scheduler FSM. The left sample is issued first, then the right sample,
  // then both results drain back from the shared pipeline.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_L = 3'd1,
    ST_ISSUE_R = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLD    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/issue_delay_counter.sv
// Counts cycles from the left-issue cycle to time both result captures.
// Latency: cap_left PIPE_LAT cycles after start, cap_right one cycle later.
// Backpressure: none; a start pulse restarts the count unconditionally.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   start       high during the ISSUE_L cycle
//   cap_left    capture dist_result as the left result this cycle
//   cap_right   capture dist_result as the right result this cycle
module issue_delay_counter
  import effects_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic cap_left,
  output logic cap_right
);

  // Count value seen during the cycle that is k cycles after the issue cycle
  // is k, so the captures land on exact counter matches.
  localparam logic [DLY_CNT_W-1:0] CAP_L_CNT = DLY_CNT_W'(PIPE_LAT);
  localparam logic [DLY_CNT_W-1:0] CAP_R_CNT = DLY_CNT_W'(PIPE_LAT + 1);

  logic [DLY_CNT_W-1:0] cnt;
  logic                 run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= DLY_CNT_W'(1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == CAP_R_CNT) begin
        // Both results captured; park until the next issue.
        cnt <= '0;
        run <= 1'b0;
      end else begin
        cnt <= cnt + DLY_CNT_W'(1);
      end
    end
  end

  assign cap_left  = run && (cnt == CAP_L_CNT);
  assign cap_right = run && (cnt == CAP_R_CNT);

endmodule

// File: rtl/distortion_scheduler.sv
// Time-shares one distortion pipeline between the left and right channels.
// Latency: accept to out_valid is PIPE_LAT+3 cycles; one frame per PIPE_LAT+5 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready low while a frame is in flight.
//
// Ports:
//   clk, rst_n              clock and async active-low reset
//   in_valid/in_ready       stereo frame input handshake
//   in_left, in_right       input samples
//   gain_l, gain_r          per-channel gains, sampled at accept
//   dist_sample, dist_gain  issue port to the shared pipeline (0 when not issuing)
//   dist_result             pipeline result, PIPE_LAT cycles after issue
//   out_valid/out_ready     processed frame output handshake
//   out_left, out_right     processed samples, stable while out_valid
//   busy                    high whenever the FSM is not IDLE
//
// PIPE_LAT must be in 1..PIPE_LAT_MAX.
module distortion_scheduler
  import effects_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int GAIN_W   = GAIN_W_DEF,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic [GAIN_W-1:0]   gain_l,
  input  logic [GAIN_W-1:0]   gain_r,
  output logic [SAMPLE_W-1:0] dist_sample,
  output logic [GAIN_W-1:0]   dist_gain,
  input  logic [SAMPLE_W-1:0] dist_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                busy
);

  sched_state_t        state;
  logic [SAMPLE_W-1:0] lat_right;
  logic [GAIN_W-1:0]   lat_gain_r;
  logic                cap_left;
  logic                cap_right;
  logic                in_hs;
  logic                out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  issue_delay_counter #(
    .PIPE_LAT (PIPE_LAT)
  ) u_issue_delay_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (state == ST_ISSUE_L),
    .cap_left  (cap_left),
    .cap_right (cap_right)
  );

  // All outputs are registered alongside the state. The left sample and
  // gain are loaded straight into the issue registers at accept, so those
  // registers are the left latch; only the right side needs its own latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      dist_sample <= '0;
      dist_gain   <= '0;
      lat_right   <= '0;
      lat_gain_r  <= '0;
      out_left    <= '0;
      out_right   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            lat_right   <= in_right;
            lat_gain_r  <= gain_r;
            dist_sample <= in_left;
            dist_gain   <= gain_l;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_ISSUE_L;
          end else begin
            // in_ready rises one cycle into IDLE, so the HOLD exit cycle
            // and the first IDLE cycle never accept.
            in_ready <= 1'b1;
          end
        end

        ST_ISSUE_L: begin
          dist_sample <= lat_right;
          dist_gain   <= lat_gain_r;
          state       <= ST_ISSUE_R;
        end

        ST_ISSUE_R: begin
          dist_sample <= '0;
          dist_gain   <= '0;
          state       <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // The right capture is always at least one cycle into DRAIN.
          if (cap_right) begin
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          in_ready    <= 1'b0;
          busy        <= 1'b0;
          out_valid   <= 1'b0;
          dist_sample <= '0;
          dist_gain   <= '0;
        end
      endcase

      // Captures only fire before HOLD, so the output pair is stable there.
      if (cap_left) begin
        out_left <= dist_result;
      end
      if (cap_right) begin
        out_right <= dist_result;
      end
    end
  end

endmodule

// File: tb/tb_distortion_scheduler.sv
// Self-checking bench: three schedulers (PIPE_LAT 2, 1, 7) share stimulus,
// each with a delay-line pipeline stub and a frame-timeline reference model.
module tb_distortion_scheduler;

  localparam int NINST = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic [10:0] gain_l;
  logic [10:0] gain_r;

  logic        in_ready_v    [NINST];
  logic [15:0] dist_sample_v [NINST];
  logic [10:0] dist_gain_v   [NINST];
  logic [15:0] dist_result_v [NINST];
  logic        out_valid_v   [NINST];
  logic [15:0] out_left_v    [NINST];
  logic [15:0] out_right_v   [NINST];
  logic        busy_v        [NINST];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int PL = (g == 0) ? 2 : (g == 1) ? 1 : 7;

    distortion_scheduler #(
      .SAMPLE_W (16),
      .GAIN_W   (11),
      .PIPE_LAT (PL)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready_v[g]),
      .in_left     (in_left),
      .in_right    (in_right),
      .gain_l      (gain_l),
      .gain_r      (gain_r),
      .dist_sample (dist_sample_v[g]),
      .dist_gain   (dist_gain_v[g]),
      .dist_result (dist_result_v[g]),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_left    (out_left_v[g]),
      .out_right   (out_right_v[g]),
      .busy        (busy_v[g])
    );

    // Pipeline stub: dist_result is dist_sample delayed by PL cycles.
    logic [15:0] pipe [PL];
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PL; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= dist_sample_v[g];
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign dist_result_v[g] = pipe[PL-1];

    // Reference model on a cycle timeline: a frame accepted in cycle A issues
    // left in A+1, right in A+2, is valid from A+PL+3 until taken in cycle H,
    // and the next frame may be accepted from H+2. Reset drops everything.
    int          cyc      = 0;
    int          ready_at = 0;
    bit          in_frame = 0;
    int          acc      = 0;
    int          k;
    bit          exp_rdy;
    bit          exp_ov;
    logic [15:0] exp_ds;
    logic [10:0] exp_dg;
    logic [15:0] fl, fr;
    logic [10:0] fgl, fgr;
    string       pfx;

    initial pfx = $sformatf("p%0d_", PL);

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        check_eq({pfx, "rst_in_ready"},  32'(in_ready_v[g]),    32'd0);
        check_eq({pfx, "rst_out_valid"}, 32'(out_valid_v[g]),   32'd0);
        check_eq({pfx, "rst_busy"},      32'(busy_v[g]),        32'd0);
        check_eq({pfx, "rst_dist_smp"},  32'(dist_sample_v[g]), 32'd0);
        check_eq({pfx, "rst_dist_gain"}, 32'(dist_gain_v[g]),   32'd0);
        check_eq({pfx, "rst_out_left"},  32'(out_left_v[g]),    32'd0);
        check_eq({pfx, "rst_out_right"}, 32'(out_right_v[g]),   32'd0);
        in_frame = 0;
        ready_at = cyc + 2;
      end else if (!in_frame) begin
        exp_rdy = (cyc >= ready_at);
        check_eq({pfx, "idle_in_ready"},  32'(in_ready_v[g]),    32'(exp_rdy));
        check_eq({pfx, "idle_out_valid"}, 32'(out_valid_v[g]),   32'd0);
        check_eq({pfx, "idle_busy"},      32'(busy_v[g]),        32'd0);
        check_eq({pfx, "idle_dist_smp"},  32'(dist_sample_v[g]), 32'd0);
        check_eq({pfx, "idle_dist_gain"}, 32'(dist_gain_v[g]),   32'd0);
        if (in_valid && exp_rdy) begin
          in_frame = 1;
          acc = cyc;
          fl  = in_left;
          fr  = in_right;
          fgl = gain_l;
          fgr = gain_r;
        end
      end else begin
        k = cyc - acc;
        exp_ds = (k == 1) ? fl  : (k == 2) ? fr  : 16'd0;
        exp_dg = (k == 1) ? fgl : (k == 2) ? fgr : 11'd0;
        exp_ov = (k >= PL + 3);
        check_eq({pfx, "run_in_ready"},  32'(in_ready_v[g]),    32'd0);
        check_eq({pfx, "run_busy"},      32'(busy_v[g]),        32'd1);
        check_eq({pfx, "run_dist_smp"},  32'(dist_sample_v[g]), 32'(exp_ds));
        check_eq({pfx, "run_dist_gain"}, 32'(dist_gain_v[g]),   32'(exp_dg));
        check_eq({pfx, "run_out_valid"}, 32'(out_valid_v[g]),   32'(exp_ov));
        if (exp_ov) begin
          check_eq({pfx, "out_left"},  32'(out_left_v[g]),  32'(fl));
          check_eq({pfx, "out_right"}, 32'(out_right_v[g]), 32'(fr));
          if (out_ready) begin
            in_frame = 0;
            ready_at = cyc + 2;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Offers one frame and returns in the cycle after the handshake (ISSUE_L).
  // Only called when all instances are idle, so all three accept together.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input logic [10:0] gl, input logic [10:0] gr);
    bit hs = 0;
    in_left  = l;
    in_right = r;
    gain_l   = gl;
    gain_r   = gr;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      if (in_ready_v[0]) hs = 1;
      step();
    end
    in_valid = 1'b0;
    if (!hs) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int accepted;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_left   = '0;
    in_right  = '0;
    gain_l    = '0;
    gain_r    = '0;
    step();
    step();
    step();
    rst_n = 1'b1;
    idle(4);

    // Basic frame on all three latencies.
    send_frame(16'h1234, 16'hABCD, 11'h100, 11'h200);
    idle(20);

    // Long HOLD backpressure.
    out_ready = 1'b0;
    send_frame(16'h5A5A, 16'hC3C3, 11'h011, 11'h022);
    for (int i = 0; i < 20; i++) step();
    out_ready = 1'b1;
    idle(20);

    // Gain change during ISSUE_L affects only the next frame.
    send_frame(16'h0F0F, 16'hF0F0, 11'h010, 11'h033);
    gain_l = 11'h7FF;
    idle(20);
    send_frame(16'h1111, 16'h2222, 11'h7FF, 11'h033);
    idle(20);

    // Continuous in_valid, three frames on the PIPE_LAT=2 instance.
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && accepted < 3; i++) begin
      if (in_ready_v[0]) accepted++;
      step();
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      gain_l   = 11'($urandom);
      gain_r   = 11'($urandom);
    end
    in_valid = 1'b0;
    check_eq("stream_accepts", 32'(accepted), 32'd3);
    idle(20);

    // Reset pulse during DRAIN, then a clean frame.
    send_frame(16'hDEAD, 16'hBEEF, 11'h155, 11'h2AA);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("async_busy",      32'(busy_v[0]),      32'd0);
    check_eq("async_out_left",  32'(out_left_v[0]),  32'd0);
    check_eq("async_dist_gain", 32'(dist_gain_v[0]), 32'd0);
    step();
    rst_n = 1'b1;
    idle(20);
    send_frame(16'h8001, 16'h7FFE, 11'h400, 11'h3FF);
    idle(20);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_left   = 16'($urandom);
      in_right  = 16'($urandom);
      gain_l    = 11'($urandom);
      gain_r    = 11'($urandom);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
